pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of clock cycles `level` is held high per event; legal range 1..255.
REQ-002 SHALL have parameter GAP, default 2: minimum number of low cycles between consecutive high phases; legal range 1..255.
REQ-003 SHALL have parameter DEPTH, default 7: maximum count of queued events; legal range 1..255.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port trigger, input, 1 bit: event strobe; each cycle sampled high counts as one event.
REQ-007 SHALL have port clear, input, 1 bit: synchronous abort.
REQ-008 SHALL have port level, output, 1 bit, registered: the stretched output.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port pending, output, 8 bits: the number of events currently queued.

Function
REQ-011 SHALL implement an FSM with states IDLE, HIGH and LOW_GAP, plus a hold counter and a pending counter.
REQ-012 SHALL, in IDLE with trigger=1 at edge N, enter HIGH with level=1 from edge N+1, one cycle of latency.
REQ-013 SHALL, in HIGH, hold level=1 for exactly WIDTH cycles, then enter LOW_GAP with level=0.
REQ-014 SHALL, in LOW_GAP, hold level=0 for exactly GAP cycles; at the end, enter HIGH and decrement pending if pending>0, otherwise enter IDLE.
REQ-015 SHALL, on trigger=1 in HIGH or LOW_GAP, increment pending, saturating at DEPTH; an event arriving at DEPTH is dropped.
REQ-016 SHALL, when trigger=1 coincides with the pending decrement at the end of LOW_GAP, leave pending unchanged.
REQ-017 SHALL, on trigger=1 on the last LOW_GAP cycle with pending=0, go directly to HIGH with no extra low cycle, because the event is counted and consumed in the same cycle.
REQ-018 SHALL, on clear=1, go to IDLE on the next edge with level=0, pending=0 and the hold counter at 0, overriding any trigger in the same cycle.
REQ-019 SHALL never produce a high phase shorter or longer than WIDTH cycles, except when cut short by clear or reset.
REQ-020 SHALL hold pending and the hold counter unchanged in IDLE when no trigger is present.

Reset
REQ-021 SHALL, on reset_n=0 at any time including mid-HIGH, immediately force state=IDLE, level=0, busy=0, pending=0, hold counter=0, and overflow=0 where present.
REQ-022 SHALL ignore trigger on the first rising edge after reset_n deasserts only if reset_n is still low at that edge; otherwise trigger is accepted normally.

Configuration
REQ-023 SHALL, with macro PULSE_STRETCHER_OVERFLOW_EN defined, add output port overflow, 1 bit, registered, sticky: set on the edge after an event is dropped at pending=DEPTH, cleared only by clear or reset.
REQ-024 SHALL, without PULSE_STRETCHER_OVERFLOW_EN, omit the overflow port and its logic while keeping all other behaviour identical.

Verification
REQ-025 SHALL verify single event: WIDTH=8, GAP=2, one-cycle trigger at edge 10 -> level high for edges 11..18, busy low from edge 21, pending stays 0.
REQ-026 SHALL verify a queued burst: trigger for 3 consecutive cycles starting in IDLE -> 3 high phases of 8 cycles each separated by exactly 2 low cycles, pending sequence 1,2 then 1,0.
REQ-027 SHALL verify saturation: DEPTH=7 with 10 triggers during the first HIGH -> pending=7, 8 high phases total, overflow=1 when the macro is defined.
REQ-028 SHALL verify mid-operation abort: clear asserted in cycle 4 of HIGH with pending=3 and trigger=1 -> next edge level=0, pending=0, busy=0, overflow=0.
REQ-029 SHALL verify asynchronous reset: reset_n pulsed low mid-LOW_GAP, between clock edges -> level, busy and pending all 0 immediately, before the next clock edge.
REQ-030 SHALL verify the boundary case: trigger on the last LOW_GAP cycle with pending=0 -> level high on the very next edge with pending remaining 0.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: each trigger produces a WIDTH-cycle high phase on `level`, spaced by
// at least GAP low cycles, with up to DEPTH events queued. Define PULSE_STRETCHER_OVERFLOW_EN for the sticky overflow flag.
module pulse_stretcher #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int DEPTH = 7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       trigger,
    input  logic       clear,
    output logic       level,
    output logic       busy,
    output logic [7:0] pending
`ifdef PULSE_STRETCHER_OVERFLOW_EN
    ,
    output logic       overflow
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HIGH    = 2'd1,
        LOW_GAP = 2'd2
    } state_t;

    localparam logic [7:0] WIDTH_LAST = 8'(WIDTH - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);
    localparam logic [7:0] DEPTH_MAX  = 8'(DEPTH);

    state_t     state;
    state_t     state_next;
    logic [7:0] hold;
    logic [7:0] hold_next;
    logic [7:0] pending_next;
    logic       level_next;
    logic       at_depth;
    logic       high_end;
    logic       gap_end;

    assign at_depth = (pending == DEPTH_MAX);
    assign high_end = (state == HIGH) && (hold == WIDTH_LAST);
    assign gap_end  = (state == LOW_GAP) && (hold == GAP_LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            hold    <= 8'd0;
            pending <= 8'd0;
            level   <= 1'b0;
        end else begin
            state   <= state_next;
            hold    <= hold_next;
            pending <= pending_next;
            level   <= level_next;
        end
    end

    // At the last gap cycle a queued event (or a fresh trigger, which is counted and
    // consumed at once) restarts the high phase without an extra low cycle.
    always_comb begin
        state_next   = state;
        hold_next    = hold;
        pending_next = pending;
        level_next   = level;
        if (clear) begin
            state_next   = IDLE;
            hold_next    = 8'd0;
            pending_next = 8'd0;
            level_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state_next = HIGH;
                        hold_next  = 8'd0;
                        level_next = 1'b1;
                    end
                end
                HIGH: begin
                    if (trigger && !at_depth) begin
                        pending_next = pending + 8'd1;
                    end
                    if (high_end) begin
                        state_next = LOW_GAP;
                        hold_next  = 8'd0;
                        level_next = 1'b0;
                    end else begin
                        hold_next = hold + 8'd1;
                    end
                end
                LOW_GAP: begin
                    if (gap_end) begin
                        hold_next = 8'd0;
                        if ((pending != 8'd0) || trigger) begin
                            state_next = HIGH;
                            level_next = 1'b1;
                            if ((pending != 8'd0) && !trigger) begin
                                pending_next = pending - 8'd1;
                            end
                        end else begin
                            state_next = IDLE;
                            level_next = 1'b0;
                        end
                    end else begin
                        hold_next = hold + 8'd1;
                        if (trigger && !at_depth) begin
                            pending_next = pending + 8'd1;
                        end
                    end
                end
                default: begin
                    state_next   = IDLE;
                    hold_next    = 8'd0;
                    pending_next = 8'd0;
                    level_next   = 1'b0;
                end
            endcase
        end
    end

`ifdef PULSE_STRETCHER_OVERFLOW_EN
    logic drop;

    // A trigger at the final gap cycle is consumed directly, so it is never a drop.
    assign drop = trigger && at_depth &&
                  ((state == HIGH) || ((state == LOW_GAP) && !gap_end));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: a timeline model (absolute start cycle of the
// current high phase plus a queue count) is compared every cycle, plus directed literal checks.
module tb_pulse_stretcher;

    localparam int W = 8;
    localparam int G = 2;
    localparam int D = 7;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       trigger = 1'b0;
    logic       clear = 1'b0;
    logic       level;
    logic       busy;
    logic [7:0] pending;
`ifdef PULSE_STRETCHER_OVERFLOW_EN
    logic       overflow;
`endif

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    int m_cyc = 0;
    int m_hs = 0;
    int m_pend = 0;
    bit m_active = 1'b0;
    bit m_ovf = 1'b0;

    always #5 clock = ~clock;

    pulse_stretcher #(.WIDTH(W), .GAP(G), .DEPTH(D)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .trigger (trigger),
        .clear   (clear),
        .level   (level),
        .busy    (busy),
`ifdef PULSE_STRETCHER_OVERFLOW_EN
        .overflow(overflow),
`endif
        .pending (pending)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: a high phase occupies cycles hs..hs+W-1, its gap the next G cycles.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_pend   = 0;
            m_ovf    = 1'b0;
        end else begin
            if (clear) begin
                m_active = 1'b0;
                m_pend   = 0;
                m_ovf    = 1'b0;
            end else if (!m_active) begin
                if (trigger) begin
                    m_active = 1'b1;
                    m_hs     = m_cyc + 1;
                end
            end else if (m_cyc == m_hs + W + G - 1) begin
                if (m_pend > 0 || trigger) begin
                    if (m_pend > 0 && !trigger) m_pend = m_pend - 1;
                    m_hs = m_cyc + 1;
                end else begin
                    m_active = 1'b0;
                end
            end else if (trigger) begin
                if (m_pend < D) m_pend = m_pend + 1;
                else m_ovf = 1'b1;
            end
        end
        m_cyc = m_cyc + 1;
    end

    always @(negedge clock) begin
        if (checking) begin
            check("cyc_level", int'(level),
                  int'(m_active && m_cyc >= m_hs && m_cyc < m_hs + W));
            check("cyc_busy", int'(busy), int'(m_active));
            check("cyc_pending", int'(pending), m_pend);
`ifdef PULSE_STRETCHER_OVERFLOW_EN
            check("cyc_overflow", int'(overflow), int'(m_ovf));
`endif
        end
    end

    task automatic apply_stimulus(input logic trig, input logic clr);
        trigger = trig;
        clear   = clr;
        @(posedge clock);
        #1;
        trigger = 1'b0;
        clear   = 1'b0;
    endtask

    // Idles the inputs until busy drops, recording pending at each new high phase.
    task automatic run_until_idle(input int limit, output int high_cycles, output int starts[$]);
        logic prev;
        high_cycles = 0;
        starts = {};
        for (int i = 0; i < limit; i++) begin
            prev = level;
            apply_stimulus(1'b0, 1'b0);
            if (level && !prev) starts.push_back(int'(pending));
            if (level) high_cycles++;
            if (!busy) break;
        end
        check("idle_reached", int'(busy), 0);
    endtask

    initial begin
        int hc;
        int st[$];

        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hc;
        int st[$];

        repeat (2) @(posedge clock);
        #1;
        check("reset_level", int'(level), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pending", int'(pending), 0);
        reset_n  = 1'b1;
        checking = 1'b1;
        repeat (2) apply_stimulus(1'b0, 1'b0);

        $display("[TB] single event");
        apply_stimulus(1'b1, 1'b0);
        check("single_first_high", int'(level), 1);
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b0, 1'b0);
            check("single_hold_high", int'(level), 1);
        end
        apply_stimulus(1'b0, 1'b0);
        check("single_gap1_level", int'(level), 0);
        check("single_gap1_busy", int'(busy), 1);
        apply_stimulus(1'b0, 1'b0);
        check("single_gap2_busy", int'(busy), 1);
        apply_stimulus(1'b0, 1'b0);
        check("single_idle_busy", int'(busy), 0);
        check("single_pending", int'(pending), 0);

        $display("[TB] queued burst");
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        check("burst_pending_1", int'(pending), 1);
        apply_stimulus(1'b1, 1'b0);
        check("burst_pending_2", int'(pending), 2);
        run_until_idle(100, hc, st);
        check("burst_new_phases", st.size(), 2);
        if (st.size() == 2) begin
            check("burst_phase2_pending", st[0], 1);
            check("burst_phase3_pending", st[1], 0);
        end
        check("burst_high_cycles", hc, 21);

        $display("[TB] saturation");
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0);
        check("sat_pending", int'(pending), 7);
`ifdef PULSE_STRETCHER_OVERFLOW_EN
        check("sat_overflow", int'(overflow), 1);
`endif
        run_until_idle(200, hc, st);
        check("sat_new_phases", st.size(), 7);
        if (st.size() > 0) check("sat_phase2_pending", st[0], 6);
        check("sat_high_cycles", hc, 56);

        $display("[TB] abort");
        apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);
        check("abort_pre_pending", int'(pending), 3);
        check("abort_pre_level", int'(level), 1);
        apply_stimulus(1'b1, 1'b1);
        check("abort_level", int'(level), 0);
        check("abort_pending", int'(pending), 0);
        check("abort_busy", int'(busy), 0);
`ifdef PULSE_STRETCHER_OVERFLOW_EN
        check("abort_overflow", int'(overflow), 0);
`endif
        apply_stimulus(1'b0, 1'b0);
        check("abort_stays_idle", int'(busy), 0);

        $display("[TB] async reset mid gap");
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 1'b0);
        check("rst_pre_level", int'(level), 0);
        check("rst_pre_busy", int'(busy), 1);
        check("rst_pre_pending", int'(pending), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_level", int'(level), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_pending", int'(pending), 0);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        apply_stimulus(1'b1, 1'b0);
        check("rst_after_trigger", int'(level), 1);
        run_until_idle(100, hc, st);

        $display("[TB] trigger on last gap cycle");
        apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        check("edge_gap2_level", int'(level), 0);
        apply_stimulus(1'b1, 1'b0);
        check("edge_level", int'(level), 1);
        check("edge_pending", int'(pending), 0);
        run_until_idle(100, hc, st);
        check("edge_high_cycles", hc, 7);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
